// File: rtl/mips32_pkg.sv
// Shared definitions for the data-memory responder: word/lane widths,
// the responder FSM state type and the legal byte-enable patterns used
// by the optional alignment check.
package mips32_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [BE_W-1:0] BE_NONE = 4'b0000;
  localparam logic [BE_W-1:0] BE_B0   = 4'b0001;
  localparam logic [BE_W-1:0] BE_B1   = 4'b0010;
  localparam logic [BE_W-1:0] BE_B2   = 4'b0100;
  localparam logic [BE_W-1:0] BE_B3   = 4'b1000;
  localparam logic [BE_W-1:0] BE_H0   = 4'b0011;
  localparam logic [BE_W-1:0] BE_H1   = 4'b1100;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  // True when be is a byte/half/word pattern whose lowest lane matches the
  // byte offset; an all-zero enable is always accepted.
  function automatic logic be_aligned(input logic [BE_W-1:0] be, input logic [1:0] lane);
    case (be)
      BE_NONE:               be_aligned = 1'b1;
      BE_B0, BE_H0, BE_WORD: be_aligned = (lane == 2'd0);
      BE_B1:                 be_aligned = (lane == 2'd1);
      BE_B2, BE_H1:          be_aligned = (lane == 2'd2);
      BE_B3:                 be_aligned = (lane == 2'd3);
      default:               be_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with per-byte write enables.
// Read data is registered and reflects the word before any same-edge write.
// Contents are never reset.
module dmem_array
  import mips32_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BE_W-1:0]   wbe,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Single access port: lane-masked write plus registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (wbe[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: one outstanding request, fixed latency
// of 1+WAIT_CYCLES edges from accept to rsp_valid, range-checked addresses.
// Optional build macro DMEM_ALIGN_CHECK_EN adds byte-enable/offset checking.
module dmem_responder
  import mips32_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_t       state;
  logic [3:0]        cnt;
  logic              q_we;
  logic [WORD_W-1:0] q_addr;
  logic [WORD_W-1:0] q_wdata;
  logic [BE_W-1:0]   q_be;
  logic              rd_sel;
  logic [WORD_W-1:0] ram_rdata;
  logic              range_err;
  logic              access_err;
  logic              do_access;
  logic              ram_en;
  logic [BE_W-1:0]   ram_wbe;
  logic              accept;

  assign accept    = (state == IDLE) && req_valid && req_ready;
  assign range_err = (q_addr[WORD_W-1:AW+2] != '0);

`ifdef DMEM_ALIGN_CHECK_EN
  assign access_err = range_err || !be_aligned(q_be, q_addr[1:0]);
`else
  logic lane_unused;
  assign lane_unused = ^q_addr[1:0];
  assign access_err  = range_err;
`endif

  // The RAM is touched exactly once, on the first edge spent in RESP;
  // faulting accesses neither write nor read.
  assign do_access = (state == RESP) && !rsp_valid;
  assign ram_en    = do_access && !access_err;
  assign ram_wbe   = (ram_en && q_we) ? q_be : '0;

  // Load data comes straight from the RAM output register, which cannot
  // change while the response is held; everything else returns zero.
  assign rsp_rdata = rd_sel ? ram_rdata : '0;

  // Capture the request on the accept edge only.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_we    <= req_we;
      q_addr  <= req_addr;
      q_wdata <= req_wdata;
      q_be    <= req_be;
    end
  end

  // Responder FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            cnt       <= '0;
            state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= access_err;
            rd_sel    <= !q_we && !access_err;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_sel    <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .wbe  (ram_wbe),
    .addr (q_addr[AW+1:2]),
    .wdata(q_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver issues requests and pushes
// the reference model's expected response; a monitor pops and compares.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stall_cycles = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: word memory indexed by addr/4, lane mask from be.
  task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd, output logic err);
    logic [31:0] mask;
    int idx;
    err = (addr >= 32'(4 * DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
    case (be)
      4'b0000: ;
      4'b0001, 4'b0011, 4'b1111: if (addr % 4 != 0) err = 1'b1;
      4'b0010:                   if (addr % 4 != 1) err = 1'b1;
      4'b0100, 4'b1100:          if (addr % 4 != 2) err = 1'b1;
      4'b1000:                   if (addr % 4 != 3) err = 1'b1;
      default:                   err = 1'b1;
    endcase
`endif
    rd = 32'h0;
    if (!err) begin
      idx  = int'(addr / 4);
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      if (we) ref_mem[idx] = (ref_mem[idx] & ~mask) | (wdata & mask);
      else    rd = ref_mem[idx];
    end
  endtask

  task automatic scramble_inputs();
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    logic [31:0] erd;
    logic        eerr;
    int t;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept addr=%h", addr);
      req_valid = 1'b0;
      return;
    end
    model(we, addr, wdata, be, erd, eerr);
    exp_q.push_back('{erd, eerr});
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || rsp_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    @(negedge clk);
  endtask

  // Monitor: compares each new response, checks hold stability and latency,
  // and randomly back-pressures via rsp_ready.
  initial begin
    bit          in_rsp;
    bit          post_chk;
    logic [31:0] hold_rd;
    logic        hold_err;
    exp_t        e;
    int          a;
    in_rsp    = 1'b0;
    post_chk  = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_rsp    = 1'b0;
        post_chk  = 1'b0;
        rsp_ready = 1'b0;
      end else begin
        if (post_chk) begin
          chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
          chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
          post_chk = 1'b0;
        end
        if (rsp_valid) begin
          chk("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (!in_rsp) begin
            in_rsp   = 1'b1;
            hold_rd  = rsp_rdata;
            hold_err = rsp_err;
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_rsp actual=rsp_valid required=no_response");
            end else begin
              e = exp_q.pop_front();
              a = acc_q.pop_front();
              chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("rsp_err", 32'(rsp_err), 32'(e.err));
              chk("latency", 32'(cyc - a), 32'(1 + W));
            end
          end else begin
            chk("hold_rdata", rsp_rdata, hold_rd);
            chk("hold_err", 32'(rsp_err), 32'(hold_err));
          end
          if (stall_cycles > 0) begin
            rsp_ready = 1'b0;
            stall_cycles--;
          end else begin
            rsp_ready = ($urandom_range(0, 3) != 0);
          end
          if (rsp_ready) begin
            in_rsp   = 1'b0;
            post_chk = 1'b1;
          end
        end else begin
          rsp_ready = 1'($urandom);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int t;
    reset     = 1'b1;
    req_valid = 1'b0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("req_ready_post_reset", 32'(req_ready), 32'd1);

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF);

    // Full-word store/load, then byte merge.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_req(1'b0, 32'h10, 32'h0, 4'hF);
    do_req(1'b1, 32'h10, 32'h000000AA, 4'b0001);
    do_req(1'b0, 32'h10, 32'h0, 4'hF);
    // Out-of-range load and store must not alias onto low words.
    do_req(1'b0, 32'h400, 32'h0, 4'hF);
    do_req(1'b1, 32'h400, 32'h55AA55AA, 4'hF);
    do_req(1'b0, 32'h0, 32'h0, 4'hF);
    do_req(1'b1, 32'hFFFF_FFFC, 32'h12345678, 4'hF);
    do_req(1'b0, 32'h3FC, 32'h0, 4'hF);
    // Store with no lanes enabled leaves memory alone.
    do_req(1'b1, 32'h40, 32'hCAFEF00D, 4'b0000);
    do_req(1'b0, 32'h40, 32'h0, 4'hF);
    // Unaligned full-word store to 0x11.
    do_req(1'b1, 32'h11, 32'hA5A5_5A5A, 4'hF);
    do_req(1'b0, 32'h10, 32'h0, 4'hF);
    // Held response: five cycles of back-pressure.
    wait_drain();
    stall_cycles = 5;
    do_req(1'b0, 32'h10, 32'h0, 4'hF);
    wait_drain();

    // Randomized traffic with some out-of-range addresses and idle gaps.
    repeat (300) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a < 32'(4 * DEPTH)) a = a + 32'(4 * DEPTH);
      end else begin
        a = 32'($urandom_range(0, 4 * DEPTH - 1));
      end
      do_req(1'($urandom), a, $urandom, 4'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();

    // Reset during the wait phase of a store discards it.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = ~ref_mem[8];
    req_be    = 4'hF;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reset_test_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_req_ready", 32'(req_ready), 32'd0);
    chk("midreset_rsp_err", 32'(rsp_err), 32'd0);
    chk("midreset_rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("req_ready_post_midreset", 32'(req_ready), 32'd1);
    do_req(1'b0, 32'h20, 32'h0, 4'hF);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning word count of the backing store (power of two, 4..65536).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait states per access (0..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes occur on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, request present.
REQ-006 The block SHALL have port req_ready, output, 1, request accepted when high together with req_valid.
REQ-007 The block SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32, the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32, store data in word lanes.
REQ-010 The block SHALL have port req_be, input, 4, byte-lane enables (bit i = bits 8i+7:8i).
REQ-011 The block SHALL have port rsp_valid, output, 1, response present.
REQ-012 The block SHALL have port rsp_ready, input, 1, response consumed when high together with rsp_valid.
REQ-013 The block SHALL have port rsp_rdata, output, 32, load data as the full word.
REQ-014 The block SHALL have port rsp_err, output, 1, access error flag.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-016 On accept (IDLE, req_valid = 1), the block SHALL latch we/addr/wdata/be and go to WAIT if WAIT_CYCLES > 0, else to RESP.
REQ-017 In WAIT, a 4-bit counter SHALL count WAIT_CYCLES edges and then go to RESP; latency SHALL be accept edge N -> rsp_valid high after edge N+1+WAIT_CYCLES.
REQ-018 On entry to RESP, a store SHALL commit only the enabled lanes, and a load SHALL capture word[req_addr[log2(DEPTH_WORDS)+1:2]] into rsp_rdata.
REQ-019 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until rsp_ready = 1, then go to IDLE; there is no same-cycle re-accept (minimum 1 IDLE cycle between requests).
REQ-020 A store response SHALL return rsp_rdata = 0.
REQ-021 For req_addr >= 4*DEPTH_WORDS, the block SHALL set rsp_err = 1, write nothing, and return rsp_rdata = 0 with the normal latency.
REQ-022 A store with req_be = 0 SHALL leave memory unchanged and respond with rsp_err = 0.
REQ-023 Request inputs outside an accept cycle SHALL be ignored.

Reset
REQ-024 Asserting reset at any time SHALL force IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, and discard any in-flight access (uncommitted stores are lost).
REQ-025 req_ready SHALL be 0 while reset is high and 1 on the first cycle after deassertion.
REQ-026 Memory contents SHALL NOT be reset.

Configuration
REQ-027 With DMEM_ALIGN_CHECK_EN defined, the block SHALL accept only req_be in {0001, 0010, 0100, 1000, 0011, 1100, 1111}, with req_addr[1:0] equal to the lowest enabled lane (0000 exempt); any violation SHALL give rsp_err = 1, no write and rsp_rdata = 0.
REQ-028 Without DMEM_ALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored, any req_be SHALL be legal, and the check logic SHALL be absent.

Structure
REQ-029 The shared package mips32_pkg SHALL hold the FSM state typedef (IDLE/WAIT/RESP), WORD_W = 32, BE_W = 4 and the legal-byte-enable constants.
REQ-030 The block SHALL contain one sub-module, dmem_array: synchronous single-port word RAM with per-byte write enable and no reset.

Verification
REQ-031 Store addr 0x10, wdata 0xDEADBEEF, be 1111, then load 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, with rsp_valid 3 cycles after each accept (WAIT_CYCLES = 2).
REQ-032 Store 0x000000AA with be 0001 to 0x10 over 0xDEADBEEF, then load -> 0xDEADBEAA.
REQ-033 Load 0x400 with DEPTH_WORDS = 256 -> rsp_err 1, rsp_rdata 0; memory unchanged.
REQ-034 Hold rsp_ready = 0 for 5 cycles in RESP -> outputs stable and req_ready 0; release -> IDLE, then req_ready 1 one cycle later.
REQ-035 Assert reset during WAIT of a store to 0x20 -> rsp_valid 0 immediately; later load 0x20 returns the prior value.
REQ-036 With DMEM_ALIGN_CHECK_EN, store to addr 0x11 with be 1111 -> rsp_err 1 and no write; without the macro -> write to word 4 and rsp_err 0.
